// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback,
// drives datapath selects and enables, and counts retired instructions.
module mips_mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic [2:0]       alu_control,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic [1:0]       pcsource,
  output logic             pc_en,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    BEQ    = 4'd8,
    IEX    = 4'd9,
    IWB    = 4'd10,
    JMP    = 4'd11
  } state_t;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_NOP = 3'd4;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam logic [CNT_W-1:0] ONE = 1;

  state_t cur, nxt;
  logic [2:0] fn_alu;
  logic fn_ok;
  logic retire;

  logic pc_en_s, irwrite_s, memread_s;
  logic memwrite_s, regwrite_s, illegal_s;

  always_comb begin
    fn_alu = ALU_NOP;
    fn_ok  = 1'b1;
    unique case (1'b1)
      (funct == 6'h20): fn_alu = ALU_ADD;
      (funct == 6'h22): fn_alu = ALU_SUB;
      (funct == 6'h24): fn_alu = ALU_AND;
      (funct == 6'h25): fn_alu = ALU_OR;
      (funct == 6'h2A): fn_alu = ALU_SLT;
      default:          fn_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= FETCH;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt         = FETCH;
    alu_control = ALU_NOP;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    iord        = 1'b0;
    memread_s   = 1'b0;
    memwrite_s  = 1'b0;
    irwrite_s   = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite_s  = 1'b0;
    pcsource    = 2'b00;
    pc_en_s     = 1'b0;
    illegal_s   = 1'b0;
    unique case (cur)
      FETCH: begin
        memread_s   = 1'b1;
        irwrite_s   = 1'b1;
        alusrcb     = 2'b01;
        alu_control = ALU_ADD;
        pc_en_s     = 1'b1;
        nxt         = DECODE;
      end
      DECODE: begin
        alusrcb     = 2'b11;
        alu_control = ALU_ADD;
        case (opcode)
          6'h23, 6'h2B: nxt = MEMADR;
          6'h00:        nxt = REX;
          6'h04:        nxt = BEQ;
          6'h08, 6'h0A: nxt = IEX;
          6'h02:        nxt = JMP;
          default:      illegal_s = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca     = 1'b1;
        alusrcb     = 2'b10;
        alu_control = ALU_ADD;
        nxt         = (opcode == 6'h23) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord      = 1'b1;
        memread_s = 1'b1;
        nxt       = MEMWB;
      end
      MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      REX: begin
        alusrca     = 1'b1;
        alu_control = fn_alu;
        illegal_s   = ~fn_ok;
        nxt         = RWB;
      end
      RWB: begin
        regdst     = 1'b1;
        regwrite_s = fn_ok;
      end
      BEQ: begin
        alusrca     = 1'b1;
        alu_control = ALU_SUB;
        pcsource    = 2'b01;
        pc_en_s     = zero;
      end
      IEX: begin
        alusrca     = 1'b1;
        alusrcb     = 2'b10;
        alu_control = (opcode == 6'h0A) ? ALU_SLT : ALU_ADD;
        nxt         = IWB;
      end
      IWB: begin
        regwrite_s = 1'b1;
      end
      JMP: begin
        pcsource = 2'b10;
        pc_en_s  = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  // Write strobes are held off for as long as reset is asserted.
  assign pc_en    = pc_en_s    & rst_n;
  assign irwrite  = irwrite_s  & rst_n;
  assign memread  = memread_s  & rst_n;
  assign memwrite = memwrite_s & rst_n;
  assign regwrite = regwrite_s & rst_n;
  assign illegal  = illegal_s  & rst_n;

  assign state = cur;

  assign retire = (cur == MEMWB) || (cur == MEMWR) ||
                  (cur == RWB)   || (cur == BEQ)   ||
                  (cur == IWB)   || (cur == JMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
    end else if (retire) begin
      instr_count <= instr_count + ONE;
    end
  end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle control unit for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath muxes and write enables. It also generates the 3-bit `control` code consumed directly by the downstream ALU. A retired-instruction counter is included for bring-up and performance checks.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `opcode`: input, 6 bits. Instruction bits [31:26], from the instruction register.
- `funct`: input, 6 bits. Instruction bits [5:0], from the instruction register.
- `zero`: input, 1 bit. ALU zero flag.
- `alu_control`: output, 3 bits. ALU op code:
  - 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT.
  - 4 is the no-op code; the ALU outputs 0.
- `alusrca`: output, 1 bit. 0 selects PC; 1 selects register A.
- `alusrcb`: output, 2 bits. 00 B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate << 2.
- `iord`: output, 1 bit. Memory address select: 0 PC, 1 ALUOut.
- `memread`: output, 1 bit. Memory read strobe.
- `memwrite`: output, 1 bit. Memory write strobe.
- `irwrite`: output, 1 bit. Instruction register load.
- `regdst`: output, 1 bit. Write register select: 0 rt, 1 rd.
- `memtoreg`: output, 1 bit. Writeback data select: 0 ALUOut, 1 MDR.
- `regwrite`: output, 1 bit. Register file write.
- `pcsource`: output, 2 bits. 00 ALU result, 01 ALUOut, 10 jump target.
- `pc_en`: output, 1 bit. PC load enable (unconditional write OR taken branch).
- `illegal`: output, 1 bit. One-cycle pulse on an unsupported opcode or funct.
- `state`: output, 4 bits. Current state encoding, for debug.
- `instr_count`: output, `CNT_W` bits. Count of retired instructions.

## Operation
**States and encodings:**
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BEQ=8, IEX=9, IWB=10, JMP=11.

**Outputs:**
- Moore outputs, decoded from the registered state only, except `pc_en` in BEQ.
- Any signal not listed for a state is 0.
- `alu_control` is 4 wherever no ALU operation is listed.

**Per-state behaviour:**
- FETCH: `memread`=1, `irwrite`=1, `alusrcb`=01, `alu_control`=2, `pcsource`=00, `pc_en`=1. Next state is DECODE.
- DECODE: `alusrcb`=11, `alu_control`=2 (branch target into ALUOut). Next state by opcode:
  - 0x23 or 0x2B → MEMADR.
  - 0x00 → REX.
  - 0x04 → BEQ.
  - 0x08 or 0x0A → IEX.
  - 0x02 → JMP.
  - Any other opcode → FETCH, with `illegal`=1.
- MEMADR: `alusrca`=1, `alusrcb`=10, `alu_control`=2. Next state is MEMRD for opcode 0x23, MEMWR for 0x2B.
- MEMRD: `iord`=1, `memread`=1. Next state is MEMWB.
- MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0. Next state is FETCH.
- MEMWR: `iord`=1, `memwrite`=1. Next state is FETCH.
- REX: `alusrca`=1, `alusrcb`=00. `alu_control` by funct:
  - 0x20 → 2, 0x22 → 6, 0x24 → 0, 0x25 → 1, 0x2A → 7.
  - Any other funct → 4, with `illegal`=1.
  - Next state is RWB.
- RWB: `regdst`=1, `memtoreg`=0. `regwrite`=1 only if the funct is supported. Next state is FETCH.
- BEQ: `alusrca`=1, `alusrcb`=00, `alu_control`=6, `pcsource`=01, `pc_en`=`zero`. Next state is FETCH.
- IEX: `alusrca`=1, `alusrcb`=10. `alu_control`=2 for addi, 7 for slti. Next state is IWB.
- IWB: `regwrite`=1, `regdst`=0, `memtoreg`=0. Next state is FETCH.
- JMP: `pcsource`=10, `pc_en`=1. Next state is FETCH.

**Instruction register and opcode sampling:**
- The instruction register loads at the end of FETCH.
- `opcode` and `funct` are stable from DECODE until the next FETCH.
- The block samples no other instruction fields.

**Retired-instruction counter (`instr_count`):**
- Increments by 1 on every transition into FETCH from MEMWB, MEMWR, RWB, BEQ, IWB or JMP.
- Illegal-funct R-type instructions are counted.
- Illegal-opcode returns from DECODE are not counted.
- Wraps from all-ones to 0 with no saturation or flag.

## Timing
**Reset:**
- `rst_n` low asynchronously forces `state`=FETCH and `instr_count`=0.
- While `rst_n` is low, `pc_en`, `irwrite`, `memread`, `memwrite`, `regwrite` and `illegal` are forced to 0. The remaining outputs show their FETCH values.
- Reset asserted mid-instruction aborts the instruction: no further writes occur and the partial instruction is not counted.
- The first FETCH cycle is the first rising edge with `rst_n` high.

**Cycle counts, FETCH through the last state inclusive:**
- lw: 5
- sw, R-type, addi, slti: 4
- beq, j: 3
- Illegal opcode: 2

**Other timing rules:**
- A taken branch loads the PC at the end of the BEQ cycle. An untaken branch leaves the PC at PC+4, written in FETCH.
- `illegal` is high for exactly the one cycle in DECODE (bad opcode) or REX (bad funct).

## Test plan
- **Reset:** Hold `rst_n`=0 for 3 cycles, release with opcode 0x00. Expect `state`=0, all enables 0 during reset, then FETCH outputs (`pc_en`=1, `irwrite`=1, `alu_control`=2), then `state`=1.
- **Load then store:** Run lw (0x23) then sw (0x2B). Expect state sequences 0,1,2,3,4 and 0,1,2,5. Expect `regwrite`+`memtoreg` in state 4 and `memwrite` in state 5. `instr_count` ends at 2 after 9 cycles.
- **R-type sweep:** Apply R-type with funct 0x20/0x22/0x24/0x25/0x2A. Expect `alu_control` in REX of 2/6/0/1/7 and `regwrite`=1, `regdst`=1 in RWB. Then funct 0x00: expect `alu_control`=4, `illegal` pulse, `regwrite`=0, `instr_count` still incremented.
- **beq:** Run beq with `zero`=1, then with `zero`=0. Expect `pc_en`=1, `pcsource`=01 in BEQ for the first and `pc_en`=0 for the second, three cycles each.
- **Illegal opcode and jump:** Opcode 0x3F: expect DECODE→FETCH, `illegal`=1 for one cycle, `instr_count` unchanged. Opcode 0x02: expect JMP with `pcsource`=10, `pc_en`=1.
- **Reset mid-instruction and counter wrap:** Assert `rst_n`=0 during MEMRD: expect immediate `state`=0, no `regwrite`, count 0. With `CNT_W`=4, retire 16 instructions: expect `instr_count` to wrap to 0.
